// File: rtl/mem_port_arbiter_if.sv
// Shared RAM port bundle: fetch handshake, data handshake and the RAM side.
// The arbiter takes the slave view; requesters/RAM model take the master view.
interface mem_port_arbiter_if;
  // fetch side
  logic        f_req_i;
  logic [63:0] f_addr_i;
  logic        f_done_o;
  logic [79:0] f_instr_o;
  logic        f_err_o;
  // data side
  logic        d_req_i;
  logic        d_we_i;
  logic [63:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic        d_done_o;
  logic [63:0] d_rdata_o;
  logic        d_err_o;
  // RAM side
  logic        mem_r_en_o;
  logic        mem_w_en_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;
  logic        mem_error_i;

  modport slave (
    input  f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_error_i,
    output f_done_o, f_instr_o, f_err_o, d_done_o, d_rdata_o, d_err_o,
           mem_r_en_o, mem_w_en_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_error_i,
    input  f_done_o, f_instr_o, f_err_o, d_done_o, d_rdata_o, d_err_o,
           mem_r_en_o, mem_w_en_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared between instruction fetch and data access.
// Data wins arbitration unless fetch has been passed over STARVE_LIMIT
// times in a row. A fetch is two 64-bit reads assembled into 10 bytes.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH0, FETCH1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic        grant_d, grant_f;
  // One transaction in flight at a time, so fetch and data share the latches.
  logic        lat_we;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [63:0] beat0;
  logic        err0;

  // Grant decisions, only meaningful in IDLE.
  always_comb begin
    grant_f = (state == IDLE) && bus.f_req_i &&
              (!bus.d_req_i || (starve_cnt == LIMIT));
    grant_d = (state == IDLE) && bus.d_req_i && !grant_f;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_f)      state_nxt = FETCH0;
               else if (grant_d) state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      FETCH0:  state_nxt = FETCH1;
      FETCH1:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port drive, purely from state so reset drops enables at once.
  always_comb begin
    bus.mem_r_en_o  = 1'b0;
    bus.mem_w_en_o  = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    case (state)
      DATA: begin
        bus.mem_addr_o = lat_addr;
        if (lat_we) begin
          bus.mem_w_en_o  = 1'b1;
          bus.mem_wdata_o = lat_wdata;
        end else begin
          bus.mem_r_en_o = 1'b1;
        end
      end
      FETCH0: begin
        bus.mem_r_en_o = 1'b1;
        bus.mem_addr_o = lat_addr;
      end
      FETCH1: begin
        bus.mem_r_en_o = 1'b1;
        bus.mem_addr_o = lat_addr + 64'd8;  // wraps modulo 2^64
      end
      default: ;
    endcase
  end

  // Request latching, starvation counter, beat capture and registered results.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt    <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      beat0         <= '0;
      err0          <= 1'b0;
      bus.d_done_o  <= 1'b0;
      bus.d_rdata_o <= '0;
      bus.d_err_o   <= 1'b0;
      bus.f_done_o  <= 1'b0;
      bus.f_instr_o <= '0;
      bus.f_err_o   <= 1'b0;
    end else begin
      bus.d_done_o <= 1'b0;
      bus.f_done_o <= 1'b0;

      if (grant_d) begin
        lat_we    <= bus.d_we_i;
        lat_addr  <= bus.d_addr_i;
        lat_wdata <= bus.d_wdata_i;
        // Only count grants that actually made fetch wait.
        if (bus.f_req_i && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      end
      if (grant_f) begin
        lat_we     <= 1'b0;
        lat_addr   <= bus.f_addr_i;
        starve_cnt <= '0;
      end

      case (state)
        DATA: begin
          bus.d_rdata_o <= lat_we ? 64'd0 : bus.mem_rdata_i;
          bus.d_err_o   <= bus.mem_error_i;
          bus.d_done_o  <= 1'b1;
        end
        FETCH0: begin
          beat0 <= bus.mem_rdata_i;
          err0  <= bus.mem_error_i;
        end
        FETCH1: begin
          // Errors never abort a fetch; both beats are always issued.
          bus.f_instr_o <= {bus.mem_rdata_i[15:0], beat0};
          bus.f_err_o   <= err0 | bus.mem_error_i;
          bus.f_done_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM model: 1 KiB byte array, address taken modulo 1024, little-endian.
  logic [7:0]  ram [1024];
  logic [63:0] rd;
  logic        err_en;
  logic [63:0] err_addr;

  always_comb begin
    rd = '0;
    for (int k = 0; k < 8; k++)
      rd[8*k +: 8] = ram[10'(bus.mem_addr_o[9:0] + 10'(k))];
  end

  assign bus.mem_rdata_i = rd;
  assign bus.mem_error_i = err_en && (bus.mem_r_en_o || bus.mem_w_en_o) &&
                           (bus.mem_addr_o == err_addr);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    string       exp_seq;
    string       got_seq;
    logic        both_en;
    logic [63:0] wdat;

    bus.f_req_i   = 1'b0;
    bus.f_addr_i  = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    err_en        = 1'b0;
    err_addr      = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    wdat = 64'h1122334455667788;
    for (int k = 0; k < 8; k++) ram[10'h100 + k] = wdat[8*k +: 8];
    for (int i = 0; i < 16; i++) ram[10'h200 + i] = 8'(i);
    for (int k = 0; k < 4; k++) ram[10'h3FC + k] = 8'(8'hA0 + k);
    for (int k = 0; k < 6; k++) ram[k] = 8'(8'hB0 + k);

    // ---- reset state
    cyc(); cyc();
    chk("rst_d_done",  bus.d_done_o, 0);
    chk("rst_f_done",  bus.f_done_o, 0);
    chk("rst_d_rdata", bus.d_rdata_o, 0);
    chk("rst_f_instr", bus.f_instr_o, 0);
    chk("rst_errs",    {bus.d_err_o, bus.f_err_o}, 0);
    chk("rst_mem",     {bus.mem_r_en_o, bus.mem_w_en_o, bus.mem_addr_o, bus.mem_wdata_o}, 0);
    rst_n = 1'b1;
    cyc();

    // ---- isolated read of 0x100
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 64'h100;
    cyc();
    chk("rd_c1_en",   {bus.mem_r_en_o, bus.mem_w_en_o}, 2'b10);
    chk("rd_c1_addr", bus.mem_addr_o, 64'h100);
    chk("rd_c1_done", bus.d_done_o, 0);
    cyc();
    chk("rd_c2_done",  bus.d_done_o, 1);
    chk("rd_c2_data",  bus.d_rdata_o, 64'h1122334455667788);
    chk("rd_c2_err",   bus.d_err_o, 0);
    chk("rd_c2_en",    {bus.mem_r_en_o, bus.mem_w_en_o}, 0);
    bus.d_req_i = 1'b0;
    cyc();
    chk("rd_c3_pulse", bus.d_done_o, 0);
    chk("rd_c3_hold",  bus.d_rdata_o, 64'h1122334455667788);

    // ---- write 0xDEADBEEF to 0x40, then read it back
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 64'h40; bus.d_wdata_i = 64'hDEADBEEF;
    cyc();
    chk("wr_c1_en",    {bus.mem_r_en_o, bus.mem_w_en_o}, 2'b01);
    chk("wr_c1_addr",  bus.mem_addr_o, 64'h40);
    chk("wr_c1_wdata", bus.mem_wdata_o, 64'hDEADBEEF);
    if (bus.mem_w_en_o)
      for (int k = 0; k < 8; k++) ram[10'(bus.mem_addr_o[9:0] + 10'(k))] = bus.mem_wdata_o[8*k +: 8];
    cyc();
    chk("wr_c2_done",  bus.d_done_o, 1);
    chk("wr_c2_rdata", bus.d_rdata_o, 0);
    chk("wr_c2_wen",   bus.mem_w_en_o, 0);
    bus.d_we_i = 1'b0; bus.d_wdata_i = '0;   // new read issued in the done cycle
    cyc();
    chk("rb_c3_done",  bus.d_done_o, 0);
    chk("rb_c3_en",    {bus.mem_r_en_o, bus.mem_w_en_o}, 2'b10);
    cyc();
    chk("rb_c4_done",  bus.d_done_o, 1);
    chk("rb_c4_data",  bus.d_rdata_o, 64'hDEADBEEF);
    bus.d_req_i = 1'b0;
    cyc();

    // ---- fetch assembly at 0x200
    bus.f_req_i = 1'b1; bus.f_addr_i = 64'h200;
    cyc();
    chk("f_c1_en",   bus.mem_r_en_o, 1);
    chk("f_c1_addr", bus.mem_addr_o, 64'h200);
    cyc();
    chk("f_c2_en",   bus.mem_r_en_o, 1);
    chk("f_c2_addr", bus.mem_addr_o, 64'h208);
    chk("f_c2_done", bus.f_done_o, 0);
    cyc();
    chk("f_c3_done",  bus.f_done_o, 1);
    chk("f_c3_instr", bus.f_instr_o, 80'h09080706050403020100);
    chk("f_c3_err",   bus.f_err_o, 0);
    bus.f_req_i = 1'b0;
    cyc();
    chk("f_c4_pulse", bus.f_done_o, 0);

    // ---- fetch wrapping past 2^64 with error on beat1 only
    err_en = 1'b1; err_addr = 64'h4;
    bus.f_req_i = 1'b1; bus.f_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    chk("fw_c1_addr", bus.mem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("fw_c1_err",  bus.mem_error_i, 0);
    cyc();
    chk("fw_c2_addr", bus.mem_addr_o, 64'h4);
    cyc();
    chk("fw_c3_done",  bus.f_done_o, 1);
    chk("fw_c3_err",   bus.f_err_o, 1);
    chk("fw_c3_instr", bus.f_instr_o, 80'hB5B4_B3B2B1B0A3A2A1A0);
    bus.f_req_i = 1'b0; err_en = 1'b0;
    cyc();

    // ---- starvation: both requesters held; expect DDDDF repeating
    exp_seq = "DDDDFDDDDF";
    got_seq = "";
    both_en = 1'b0;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 64'h100;
    bus.f_req_i = 1'b1; bus.f_addr_i = 64'h200;
    for (int c = 0; c < 60 && got_seq.len() < 10; c++) begin
      cyc();
      if (bus.mem_r_en_o && bus.mem_w_en_o) both_en = 1'b1;
      if (bus.d_done_o && bus.f_done_o) got_seq = {got_seq, "X"};
      else if (bus.d_done_o) got_seq = {got_seq, "D"};
      else if (bus.f_done_o) got_seq = {got_seq, "F"};
    end
    bus.d_req_i = 1'b0; bus.f_req_i = 1'b0;
    chk("starve_count", 128'(got_seq.len()), 128'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_ev%0d", i),
          (i < got_seq.len()) ? 128'(got_seq[i]) : 128'd0, 128'(exp_seq[i]));
    chk("starve_one_en", both_en, 0);
    chk("starve_instr",  bus.f_instr_o, 80'h09080706050403020100);
    cyc(); cyc(); cyc();

    // ---- reset in the middle of FETCH1
    bus.f_req_i = 1'b1; bus.f_addr_i = 64'h200;
    cyc();
    cyc();
    chk("rf_c2_addr", bus.mem_addr_o, 64'h208);
    rst_n = 1'b0;
    #1;
    chk("rf_rst_en",    {bus.mem_r_en_o, bus.mem_w_en_o}, 0);
    chk("rf_rst_addr",  bus.mem_addr_o, 0);
    chk("rf_rst_instr", bus.f_instr_o, 0);
    chk("rf_rst_rdata", bus.d_rdata_o, 0);
    bus.f_req_i = 1'b0;
    cyc();
    chk("rf_no_done", bus.f_done_o, 0);
    rst_n = 1'b1;
    cyc();
    bus.f_req_i = 1'b1;
    cyc();
    chk("rf2_c1_addr", bus.mem_addr_o, 64'h200);
    cyc();
    chk("rf2_c2_done", bus.f_done_o, 0);
    cyc();
    chk("rf2_c3_done",  bus.f_done_o, 1);
    chk("rf2_c3_instr", bus.f_instr_o, 80'h09080706050403020100);
    bus.f_req_i = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
